// File: rtl/wisc_pkg.sv
// rtl/wisc_pkg.sv - shared memory-stage state encodings, defaults and helpers
package wisc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_HALTED = 2'd2,
    ST_ERR    = 2'd3
  } mem_state_t;

  localparam int MEM_TIMEOUT_DEFAULT = 15;

  // Halfword accesses only: odd addresses or a combined load+store cannot be issued.
  function automatic logic mem_op_illegal(input logic [15:0] addr,
                                          input logic        rd,
                                          input logic        wr);
    return addr[0] | (rd & wr);
  endfunction

endpackage

// File: rtl/wait_timer.sv
// rtl/wait_timer.sv - memory-wait cycle counter with expiry flag
module wait_timer #(
  parameter int LIMIT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [7:0] LAST = 8'(LIMIT - 1);

  logic [7:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= 8'd0;
    end else if (clear) begin
      count <= 8'd0;
    end else if (enable) begin
      count <= count + 8'd1;
    end
  end

  // Flags the wait cycle whose increment would make the count reach LIMIT.
  assign expired = enable && (count == LAST);

endmodule

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - pipeline memory stage: issues loads/stores, retires to writeback
module mem_stage
  import wisc_pkg::*;
#(
  parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic [15:0] ex_alu_out,
  input  logic [15:0] ex_st_data,
  input  logic        ex_mem_rd,
  input  logic        ex_mem_wr,
  input  logic        ex_wb_en,
  input  logic [2:0]  ex_wb_reg,
  input  logic        ex_halt,
  output logic        stall_out,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [15:0] mem_rdata,
  output logic        wb_valid,
  output logic        wb_en,
  output logic [2:0]  wb_reg,
  output logic [15:0] wb_data,
  output logic        wb_halt,
  output logic        err
);

  mem_state_t state, next_state;

  logic accept_alu, accept_halt, accept_mem, bad_mem, mem_done, timed_out;
  logic timer_en, expired;
  logic pend_load, pend_wb_en;
  logic [2:0] pend_wb_reg;

  assign stall_out = (state != ST_IDLE);
  assign timer_en  = (state == ST_WAIT) && !mem_ack;

  wait_timer #(.LIMIT(MEM_TIMEOUT)) u_wait_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (accept_mem),
    .enable  (timer_en),
    .expired (expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state  = state;
    accept_alu  = 1'b0;
    accept_halt = 1'b0;
    accept_mem  = 1'b0;
    bad_mem     = 1'b0;
    mem_done    = 1'b0;
    timed_out   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (ex_valid) begin
          if (ex_halt) begin
            accept_halt = 1'b1;
            next_state  = ST_HALTED;
          end else if (ex_mem_rd || ex_mem_wr) begin
            if (mem_op_illegal(ex_alu_out, ex_mem_rd, ex_mem_wr)) begin
              bad_mem    = 1'b1;
              next_state = ST_ERR;
            end else begin
              accept_mem = 1'b1;
              next_state = ST_WAIT;
            end
          end else begin
            accept_alu = 1'b1;
          end
        end
      end
      // An ack in the expiry cycle still completes the access normally.
      ST_WAIT: begin
        if (mem_ack) begin
          mem_done   = 1'b1;
          next_state = ST_IDLE;
        end else if (expired) begin
          timed_out  = 1'b1;
          next_state = ST_ERR;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= 16'd0;
      mem_wdata   <= 16'd0;
      wb_valid    <= 1'b0;
      wb_en       <= 1'b0;
      wb_reg      <= 3'd0;
      wb_data     <= 16'd0;
      wb_halt     <= 1'b0;
      err         <= 1'b0;
      pend_load   <= 1'b0;
      pend_wb_en  <= 1'b0;
      pend_wb_reg <= 3'd0;
    end else begin
      wb_valid <= 1'b0;
      wb_en    <= 1'b0;
      wb_halt  <= 1'b0;
      if (accept_alu || accept_halt) begin
        wb_valid <= 1'b1;
        wb_en    <= ex_wb_en;
        wb_reg   <= ex_wb_reg;
        wb_data  <= ex_alu_out;
        wb_halt  <= accept_halt;
      end
      if (accept_mem) begin
        mem_req     <= 1'b1;
        mem_we      <= ex_mem_wr;
        mem_addr    <= ex_alu_out;
        mem_wdata   <= ex_st_data;
        pend_load   <= ex_mem_rd;
        pend_wb_en  <= ex_wb_en;
        pend_wb_reg <= ex_wb_reg;
      end
      // Stores write back their address (post-update base for STU).
      if (mem_done) begin
        mem_req  <= 1'b0;
        wb_valid <= 1'b1;
        wb_en    <= pend_wb_en;
        wb_reg   <= pend_wb_reg;
        wb_data  <= pend_load ? mem_rdata : mem_addr;
      end
      if (timed_out) mem_req <= 1'b0;
      if (bad_mem || timed_out) err <= 1'b1;
    end
  end

endmodule
